// File: rtl/branch_controller.sv
// Branch resolution controller: registers a request, drives the external comparator, resolves two cycles after acceptance.
// Taken branches redirect fetch and hold flush for FLUSH_CYCLES; optional counters under `BRANCH_STATS_EN.
module branch_controller #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_imm,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] cmp_data_1,
  output logic [31:0] cmp_data_2,
  output logic        cmp_unsigned,
  input  logic        cmp_equal,
  input  logic        cmp_lessthan,
  output logic        resolved_valid,
  output logic        resolved_taken,
  output logic        illegal,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [15:0] stat_total,
  output logic [15:0] stat_taken
);

  typedef enum logic [1:0] {IDLE, COMPARE, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  funct3_q;
  logic [31:0] pc_q;
  logic [31:0] imm_q;
  logic [2:0]  flush_cnt;
  logic        dec_taken;
  logic        dec_illegal;
  logic        accept;
  logic        in_compare;
  logic [31:0] target_sum;

  assign req_ready    = (state == IDLE);
  assign accept       = req_valid && req_ready;
  assign in_compare   = (state == COMPARE);
  assign flush        = (state == REDIRECT);
  assign cmp_unsigned = funct3_q[1];
  assign target_sum   = pc_q + imm_q;

  always_comb begin
    dec_taken   = 1'b0;
    dec_illegal = 1'b0;
    case (funct3_q)
      3'b000:  dec_taken = cmp_equal;
      3'b001:  dec_taken = !cmp_equal;
      3'b100:  dec_taken = cmp_lessthan;
      3'b101:  dec_taken = !cmp_lessthan;
      3'b110:  dec_taken = cmp_lessthan;
      3'b111:  dec_taken = !cmp_lessthan;
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = COMPARE;
      COMPARE:  state_nxt = dec_taken ? REDIRECT : IDLE;
      REDIRECT: if (flush_cnt == 3'd0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Request register doubles as the comparator operand drivers, so they hold between branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q   <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      cmp_data_1 <= '0;
      cmp_data_2 <= '0;
    end else if (accept) begin
      funct3_q   <= req_funct3;
      pc_q       <= req_pc;
      imm_q      <= req_imm;
      cmp_data_1 <= rs1_data;
      cmp_data_2 <= rs2_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt      <= '0;
      resolved_valid <= 1'b0;
      resolved_taken <= 1'b0;
      illegal        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      resolved_valid <= in_compare;
      resolved_taken <= in_compare && dec_taken;
      illegal        <= in_compare && dec_illegal;
      redirect_valid <= in_compare && dec_taken;
      if (in_compare && dec_taken) begin
        redirect_pc <= {target_sum[31:1], 1'b0};
        flush_cnt   <= 3'(FLUSH_CYCLES - 1);
      end else if (flush && flush_cnt != 3'd0) begin
        flush_cnt <= flush_cnt - 3'd1;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else begin
      if (resolved_valid && stat_total != 16'hFFFF) stat_total <= stat_total + 16'd1;
      if (resolved_valid && resolved_taken && stat_taken != 16'hFFFF) stat_taken <= stat_taken + 16'd1;
    end
  end
`else
  assign stat_total = '0;
  assign stat_taken = '0;
`endif

endmodule

// File: tb/tb_branch_controller.sv
// Scoreboard bench for branch_controller (default FLUSH_CYCLES=2); external comparator modelled here.
module tb_branch_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_pc, req_imm, rs1_data, rs2_data;
  logic [31:0] cmp_data_1, cmp_data_2;
  logic        cmp_unsigned, cmp_equal, cmp_lessthan;
  logic        resolved_valid, resolved_taken, illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] stat_total, stat_taken;

  always #5 clk = ~clk;

  assign cmp_equal    = (cmp_data_1 == cmp_data_2);
  assign cmp_lessthan = cmp_unsigned ? (cmp_data_1 < cmp_data_2)
                                     : ($signed(cmp_data_1) < $signed(cmp_data_2));

  branch_controller dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_pc(req_pc), .req_imm(req_imm),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .cmp_data_1(cmp_data_1), .cmp_data_2(cmp_data_2), .cmp_unsigned(cmp_unsigned),
    .cmp_equal(cmp_equal), .cmp_lessthan(cmp_lessthan),
    .resolved_valid(resolved_valid), .resolved_taken(resolved_taken), .illegal(illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .stat_total(stat_total), .stat_taken(stat_taken)
  );

  typedef struct {
    logic        taken;
    logic        ill;
    logic [31:0] target;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] pc, imm, a, b);
    exp_t e;
    logic eq, lts, ltu;
    logic [31:0] sum;
    eq  = (a == b);
    lts = $signed(a) < $signed(b);
    ltu = a < b;
    sum = pc + imm;
    e.taken = 1'b0;
    e.ill   = 1'b0;
    case (f3)
      3'b000: e.taken = eq;
      3'b001: e.taken = !eq;
      3'b100: e.taken = lts;
      3'b101: e.taken = !lts;
      3'b110: e.taken = ltu;
      3'b111: e.taken = !ltu;
      default: e.ill = 1'b1;
    endcase
    e.target = {sum[31:1], 1'b0};
    e.cyc    = 0;
    return e;
  endfunction

  // Advance one clock and consume any resolution against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (resolved_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resolve: resolved_valid=1 at cycle %0d, none expected", cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (cyc !== e.cyc) begin errors++; $display("FAIL resolve_cycle: got %0d want %0d", cyc, e.cyc); end
        checks++;
        if (resolved_taken !== e.taken) begin errors++; $display("FAIL resolved_taken: got %b want %b", resolved_taken, e.taken); end
        checks++;
        if (illegal !== e.ill) begin errors++; $display("FAIL illegal: got %b want %b", illegal, e.ill); end
        checks++;
        if (redirect_valid !== e.taken) begin errors++; $display("FAIL redirect_valid: got %b want %b", redirect_valid, e.taken); end
        checks++;
        if (flush !== e.taken) begin errors++; $display("FAIL flush_at_resolve: got %b want %b", flush, e.taken); end
        if (e.taken) begin
          checks++;
          if (redirect_pc !== e.target) begin errors++; $display("FAIL redirect_pc: got %h want %h", redirect_pc, e.target); end
        end
      end
    end else begin
      if (resolved_taken || illegal || redirect_valid) begin
        checks++; errors++;
        $display("FAIL idle_pulses: taken=%b illegal=%b redirect=%b without resolved_valid", resolved_taken, illegal, redirect_valid);
      end
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        checks++; errors++;
        $display("FAIL missed_resolve: got none by cycle %0d want cycle %0d", cyc, sb[0].cyc);
        e = sb.pop_front();
      end
    end
  endtask

  task automatic send(input logic [2:0] f3, input logic [31:0] pc, imm, a, b, output int acc);
    exp_t e;
    int w = 0;
    req_funct3 = f3; req_pc = pc; req_imm = imm; rs1_data = a; rs2_data = b;
    req_valid = 1'b1;
    while (!req_ready && w < 50) begin tick(); w++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: req_ready=0 after %0d cycles, want 1", w);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    e = model(f3, pc, imm, a, b);
    e.cyc = cyc + 2;
    sb.push_back(e);
    acc = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() > 0 && w < 100) begin tick(); w++; end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush); end
    checks++; if (resolved_valid !== 1'b0) begin errors++; $display("FAIL reset_resolved: got %b want 0", resolved_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
    checks++; if (cmp_data_1 !== 32'h0 || cmp_data_2 !== 32'h0) begin errors++; $display("FAIL reset_cmp_data: got %h/%h want 0/0", cmp_data_1, cmp_data_2); end
    checks++; if (stat_total !== 16'h0 || stat_taken !== 16'h0) begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_total, stat_taken); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_beq_flush();
    int a;
    send(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, a);
    checks++; if (req_ready !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL beq_compare_cycle: ready=%b flush=%b want 0/0", req_ready, flush); end
    checks++; if (cmp_data_1 !== 32'd5 || cmp_unsigned !== 1'b0) begin errors++; $display("FAIL beq_cmp_drive: got %h/%b want 5/0", cmp_data_1, cmp_unsigned); end
    tick();
    tick();
    checks++; if (flush !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL beq_flush_n3: flush=%b ready=%b want 1/0", flush, req_ready); end
    tick();
    checks++; if (flush !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL beq_end_n4: flush=%b ready=%b want 0/1", flush, req_ready); end
    checks++; if (redirect_pc !== 32'h120) begin errors++; $display("FAIL redirect_pc_hold: got %h want 00000120", redirect_pc); end
    checks++; if (cmp_data_1 !== 32'd5 || cmp_data_2 !== 32'd5) begin errors++; $display("FAIL cmp_data_hold: got %h/%h want 5/5", cmp_data_1, cmp_data_2); end
  endtask

  task automatic test_blt_bltu();
    int a;
    send(3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, a);
    drain();
    send(3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, a);
    checks++; if (cmp_unsigned !== 1'b1) begin errors++; $display("FAIL bltu_unsigned_sel: got %b want 1", cmp_unsigned); end
    tick();
    checks++; if (req_ready !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL bltu_not_taken_n2: ready=%b flush=%b want 1/0", req_ready, flush); end
    drain();
  endtask

  task automatic test_illegal_wrap();
    int a;
    send(3'b010, 32'h300, 32'h10, 32'd7, 32'd7, a);
    send(3'b011, 32'h300, 32'h10, 32'd1, 32'd9, a);
    send(3'b001, 32'hFFFF_FFF0, 32'h20, 32'd1, 32'd2, a);
    drain();
    checks++; if (redirect_pc !== 32'h0000_0010) begin errors++; $display("FAIL wrap_target: got %h want 00000010", redirect_pc); end
    send(3'b101, 32'h400, 32'h21, 32'd3, 32'd3, a);
    drain();
    checks++; if (redirect_pc !== 32'h0000_0420) begin errors++; $display("FAIL odd_target_bit0: got %h want 00000420", redirect_pc); end
  endtask

  task automatic test_random();
    int a;
    logic [2:0]  f3;
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = ($urandom_range(0, 3) == 0) ? x : $urandom;
      send(f3, $urandom, $urandom, x, y, a);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int a0, a1;
    send(3'b000, 32'h500, 32'h8, 32'd1, 32'd2, a0);
    for (int i = 0; i < 3; i++) begin
      send(3'b000, 32'h500, 32'h8, 32'd1, 32'd2, a1);
      checks++; if (a1 - a0 !== 2) begin errors++; $display("FAIL b2b_not_taken_gap: got %0d want 2", a1 - a0); end
      a0 = a1;
    end
    send(3'b000, 32'h600, 32'h8, 32'd4, 32'd4, a0);
    send(3'b001, 32'h700, 32'h8, 32'd4, 32'd4, a1);
    checks++; if (a1 - a0 !== 4) begin errors++; $display("FAIL b2b_after_taken_gap: got %0d want 4", a1 - a0); end
    drain();
  endtask

  task automatic test_reset_mid_redirect();
    int a;
    send(3'b000, 32'h800, 32'h40, 32'd9, 32'd9, a);
    tick();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL pre_abort_flush: got %b want 1", flush); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (flush !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL abort_state: flush=%b ready=%b want 0/1", flush, req_ready); end
    checks++; if (resolved_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL abort_pulses: resolved=%b redirect=%b want 0/0", resolved_valid, redirect_valid); end
    repeat (4) tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL abort_flush_stays_low: got %b want 0", flush); end
  endtask

  task automatic test_stats();
    int a;
    logic [15:0] exp_total, exp_taken;
`ifdef BRANCH_STATS_EN
    exp_total = 16'd5; exp_taken = 16'd3;
`else
    exp_total = 16'd0; exp_taken = 16'd0;
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(3'b000, 32'h10, 32'h4, 32'd1, 32'd1, a);
    send(3'b001, 32'h10, 32'h4, 32'd1, 32'd1, a);
    send(3'b100, 32'h10, 32'h4, 32'd1, 32'd2, a);
    send(3'b111, 32'h10, 32'h4, 32'd1, 32'd2, a);
    send(3'b101, 32'h10, 32'h4, 32'd3, 32'd2, a);
    drain();
    checks++; if (stat_total !== exp_total) begin errors++; $display("FAIL stat_total: got %0d want %0d", stat_total, exp_total); end
    checks++; if (stat_taken !== exp_taken) begin errors++; $display("FAIL stat_taken: got %0d want %0d", stat_taken, exp_taken); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_funct3 = '0;
    req_pc = '0; req_imm = '0; rs1_data = '0; rs2_data = '0;
    test_reset();
    test_beq_flush();
    test_blt_bltu();
    test_illegal_wrap();
    test_random();
    test_back_to_back();
    test_reset_mid_redirect();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
